// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared types and constants for the memory game
package memoria_pkg;

    localparam int N_CARDS = 16;

    localparam logic [1:0] CARD_DOWN    = 2'b00;
    localparam logic [1:0] CARD_OPEN    = 2'b01;
    localparam logic [1:0] CARD_MATCHED = 2'b10;
    localparam logic [1:0] CARD_INIT    = 2'b11;

    // [4:2] symbol, [1:0] state
    typedef logic [4:0] card_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL1,
        ST_SEL2,
        ST_SHOW,
        ST_VERIFY
    } sel_state_t;

    function automatic logic is_down(input card_t c);
        return c[1:0] == CARD_DOWN;
    endfunction

endpackage

// File: rtl/contador_turno.sv
// rtl/contador_turno.sv - loadable up-counter with clear and terminal-count flag
module contador_turno #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Clear beats load beats count
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/seleccion_cartas.sv
// rtl/seleccion_cartas.sv - per-turn cursor movement and two-card selection stage
module seleccion_cartas
    import memoria_pkg::*;
#(
    parameter int SHOW_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 750_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       turn_start,
    input  logic       move_next,
    input  logic       select,
    input  logic       verify_done,
    input  card_t      arr_cards_in  [0:N_CARDS-1],
    output card_t      arr_cards_out [0:N_CARDS-1],
    output logic [3:0] cursor,
    output logic       verify_start,
    output logic       turn_end,
    output logic       turn_timeout,
    output logic       busy
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SHOW_W-1:0] SHOW_LIMIT = SHOW_W'(SHOW_CYCLES - 1);

    sel_state_t state;
    logic [3:0] sel_pos [0:1];

    logic in_sel, valid_sel, move_ok, tmo_expire, tmo_clr, any_down;
    logic show_en, show_clr, tmo_tc, show_tc;

    // Decode this cycle's accepted actions from the registered board and state
    always_comb begin
        in_sel     = (state == ST_SEL1) || (state == ST_SEL2);
        valid_sel  = in_sel && select && is_down(arr_cards_out[cursor]);
        move_ok    = in_sel && move_next;
        tmo_expire = in_sel && tmo_tc && !valid_sel;
        tmo_clr    = ((state == ST_IDLE) && turn_start) || valid_sel || tmo_expire;
        show_en    = (state == ST_SHOW);
        show_clr   = (state != ST_SHOW);
        any_down   = 1'b0;
        for (int i = 0; i < N_CARDS; i++) begin
            if (is_down(arr_cards_in[i])) any_down = 1'b1;
        end
    end

    contador_turno #(.WIDTH(TMO_W)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmo_clr),
        .en       (in_sel),
        .load     (1'b0),
        .load_val ('0),
        .limit    (TMO_LIMIT),
        .tc       (tmo_tc)
    );

    contador_turno #(.WIDTH(SHOW_W)) u_show (
        .clk      (clk),
        .rst      (rst),
        .clr      (show_clr),
        .en       (show_en),
        .load     (1'b0),
        .load_val ('0),
        .limit    (SHOW_LIMIT),
        .tc       (show_tc)
    );

    // Turn FSM with registered board, cursor and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cursor       <= 4'd0;
            sel_pos[0]   <= 4'd0;
            sel_pos[1]   <= 4'd0;
            verify_start <= 1'b0;
            turn_end     <= 1'b0;
            turn_timeout <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < N_CARDS; i++) begin
                arr_cards_out[i] <= {3'b000, CARD_INIT};
            end
        end else begin
            verify_start <= 1'b0;
            turn_end     <= 1'b0;
            turn_timeout <= 1'b0;
            if (move_ok) cursor <= cursor + 4'd1;
            case (state)
                ST_IDLE: begin
                    if (turn_start) begin
                        for (int i = 0; i < N_CARDS; i++) begin
                            arr_cards_out[i] <= arr_cards_in[i];
                        end
                        if (any_down) begin
                            state <= ST_SEL1;
                            busy  <= 1'b1;
                        end else begin
                            turn_end <= 1'b1;
                        end
                    end
                end
                ST_SEL1, ST_SEL2: begin
                    if (valid_sel) begin
                        arr_cards_out[cursor] <= {arr_cards_out[cursor][4:2], CARD_OPEN};
                        if (state == ST_SEL1) begin
                            sel_pos[0] <= cursor;
                            state      <= ST_SEL2;
                        end else begin
                            sel_pos[1] <= cursor;
                            state      <= ST_SHOW;
                        end
                    end else if (tmo_expire) begin
                        // Only the second-pick state has a card to close again
                        if (state == ST_SEL2) begin
                            arr_cards_out[sel_pos[0]] <= {arr_cards_out[sel_pos[0]][4:2], CARD_DOWN};
                        end
                        turn_end     <= 1'b1;
                        turn_timeout <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_SHOW: begin
                    if (show_tc) begin
                        verify_start <= 1'b1;
                        state        <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (verify_done) begin
                        turn_end <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seleccion_cartas.sv
// tb/tb_seleccion_cartas.sv - scoreboard bench for seleccion_cartas
module tb_seleccion_cartas;
    import memoria_pkg::*;

    localparam int S = 5;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       turn_start = 1'b0, move_next = 1'b0, select = 1'b0, verify_done = 1'b0;
    card_t      arr_in  [0:N_CARDS-1];
    card_t      arr_out [0:N_CARDS-1];
    logic [3:0] cursor;
    logic       verify_start, turn_end, turn_timeout, busy;

    seleccion_cartas #(.SHOW_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .turn_start    (turn_start),
        .move_next     (move_next),
        .select        (select),
        .verify_done   (verify_done),
        .arr_cards_in  (arr_in),
        .arr_cards_out (arr_out),
        .cursor        (cursor),
        .verify_start  (verify_start),
        .turn_end      (turn_end),
        .turn_timeout  (turn_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // sig = {verify_start, turn_end, turn_timeout}
    typedef struct {
        int         cyc;
        logic [2:0] sig;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Game-level reference: phase 0 idle, 1 first pick, 2 second pick, 3 showing/verifying
    card_t m_board [0:N_CARDS-1];
    int    m_cur   = 0;
    int    m_phase = 0;
    int    m_last  = 0;
    int    m_pick1 = 0;
    int    m_vs    = 0;

    function automatic void push_ev(input int c, input logic [2:0] s);
        ev_t e;
        e.cyc = c;
        e.sig = s;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CARDS; i++) m_board[i] = 5'b00011;
        m_cur   = 0;
        m_phase = 0;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_pulse cyc=%0d expected_at=%0d expected_sig=%b", cyc, exp_q[0].cyc, exp_q[0].sig);
            void'(exp_q.pop_front());
        end
        if (verify_start || turn_end || turn_timeout) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d got_sig=%b expected none", cyc, {verify_start, turn_end, turn_timeout});
            end else begin
                e = exp_q.pop_front();
                if ({verify_start, turn_end, turn_timeout} !== e.sig) begin
                    n_fail++;
                    $display("FAIL pulse_sig cyc=%0d got=%b exp=%b", cyc, {verify_start, turn_end, turn_timeout}, e.sig);
                end
            end
        end
    end

    task automatic check_state();
        logic [79:0] got, want;
        for (int i = 0; i < N_CARDS; i++) begin
            got[i*5 +: 5]  = arr_out[i];
            want[i*5 +: 5] = m_board[i];
        end
        n_checks++;
        if (cursor !== 4'(m_cur)) begin
            n_fail++;
            $display("FAIL cursor cyc=%0d got=%0d exp=%0d", cyc, cursor, m_cur);
        end
        n_checks++;
        if (busy !== (m_phase != 0)) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_phase != 0);
        end
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL board cyc=%0d got=%h exp=%h", cyc, got, want);
        end
    endtask

    task automatic step(input bit r, input bit ts, input bit mv, input bit sel, input bit vd);
        int  n;
        bit  down_seen;
        n = cyc;
        rst = r; turn_start = ts; move_next = mv; select = sel; verify_done = vd;
        if (r) begin
            model_reset();
            while (exp_q.size() > 0 && exp_q[$].cyc > n) void'(exp_q.pop_back());
        end else begin
            case (m_phase)
                0: if (ts) begin
                    m_board   = arr_in;
                    down_seen = 1'b0;
                    for (int i = 0; i < N_CARDS; i++) if (arr_in[i][1:0] == 2'b00) down_seen = 1'b1;
                    if (down_seen) begin
                        m_phase = 1;
                        m_last  = n;
                    end else begin
                        push_ev(n + 1, 3'b010);
                    end
                end
                1, 2: begin
                    if (sel && m_board[m_cur][1:0] == 2'b00) begin
                        m_board[m_cur][1:0] = 2'b01;
                        m_last = n;
                        if (m_phase == 1) begin
                            m_pick1 = m_cur;
                            m_phase = 2;
                        end else begin
                            m_phase = 3;
                            m_vs    = n + S + 1;
                            push_ev(m_vs, 3'b100);
                        end
                    end else if (n == m_last + T) begin
                        if (m_phase == 2) m_board[m_pick1][1:0] = 2'b00;
                        push_ev(n + 1, 3'b011);
                        m_phase = 0;
                    end
                    if (mv) m_cur = (m_cur + 1) % N_CARDS;
                end
                default: if (n >= m_vs && vd) begin
                    push_ev(n + 1, 3'b010);
                    m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic board_fill(input logic [1:0] st);
        for (int i = 0; i < N_CARDS; i++) arr_in[i] = {3'(i / 2), st};
    endtask

    initial begin
        board_fill(2'b00);
        model_reset();

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Normal turn: pick 0 and 1, show, verify
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(S + 1);
        step(0, 0, 0, 0, 1);
        idle(2);

        // Matched card and re-select of an open card are ignored; then timeout closes pick
        board_fill(2'b00);
        arr_in[1] = {3'd0, 2'b10};
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(T + 2);

        // Cursor wrap, then select together with move at cursor 3
        board_fill(2'b00);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        idle(T + 2);

        // Select exactly on the expiry cycle wins, then a second-pick timeout
        step(0, 1, 0, 0, 0);
        idle(T - 1);
        step(0, 0, 0, 1, 0);
        idle(T + 2);

        // Board without face-down cards
        board_fill(2'b10);
        step(0, 1, 0, 0, 0);
        idle(S + 3);

        // Reset during SHOW, with ignored turn_start and verify_done first
        board_fill(2'b00);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        idle(S + 3);

        // Randomized play
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N_CARDS; i++)
                arr_in[i] = {3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(0, 3))};
            step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        idle(T + S + 5);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d pending exp=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seleccion_cartas.md
# seleccion_cartas

Turn-level card selection stage for the 16-card memory game. It latches the board at turn start and moves a player cursor over the 16 positions. It opens exactly two face-down cards (state `01`), holds them visible for a display interval, then pulses `verify_start` to the downstream pair-verification stage and waits for its `verify_done`. A per-selection inactivity timeout closes any opened card and ends the turn.

## Interface
- `SHOW_CYCLES`, default 50_000_000: cycles both opened cards stay visible before verification is requested (≥1).
- `TIMEOUT_CYCLES`, default 750_000_000: idle cycles allowed per selection before the turn is forfeited (≥2).
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `turn_start` in 1: one-cycle pulse that begins a turn; ignored unless in IDLE.
- `move_next` in 1: one-cycle pulse that advances the cursor.
- `select` in 1: one-cycle pulse that opens the card under the cursor.
- `verify_done` in 1: one-cycle pulse from the pair-verification stage.
- `arr_cards_in[0:15]` in 5 each: board snapshot. Bits [4:2] are the symbol. Bits [1:0] are the state: 00 face-down, 01 open, 10 matched, 11 uninitialised.
- `arr_cards_out[0:15]` out 5 each: registered board with this turn's opened cards.
- `cursor` out 4: current position.
- `verify_start` out 1: one-cycle pulse requesting verification.
- `turn_end` out 1: one-cycle pulse marking end of turn.
- `turn_timeout` out 1: one-cycle pulse, coincident with `turn_end` on forfeit.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE → SEL1 on `turn_start`: latch `arr_cards_in` into `arr_cards_out`, clear the timer.
  - SEL1 → SEL2 on a valid select.
  - SEL2 → SHOW on a valid select.
  - SHOW → VERIFY after SHOW_CYCLES.
  - VERIFY → IDLE on `verify_done`, pulsing `turn_end`.
- Board with no 00 card at `turn_start`: go directly to IDLE on the next cycle and pulse `turn_end`. No `verify_start`.
- Valid select: `arr_cards_out[cursor][1:0] == 00`. The block then writes 01 to that card, stores its position (pos1 or pos2), and clears the timer. Selects on 01/10/11 cards are ignored, so the same card cannot be picked twice.
- `move_next`: cursor = (cursor + 1) mod 16, wrapping 15→0. Active in SEL1/SEL2 only. The cursor is kept across turns.
- `select` and `move_next` in the same cycle: the select acts on the pre-move cursor; the move applies at the same clock edge.
- Timeout: the timer counts in SEL1/SEL2. When it reaches TIMEOUT_CYCLES−1:
  - in SEL2, write pos1 back to 00 (in SEL1 nothing is open);
  - pulse `turn_end` and `turn_timeout`;
  - go to IDLE.
  - A valid select on the expiry cycle takes priority: the card opens and the timer clears.
- SHOW: counts from 0 up to SHOW_CYCLES−1, then pulses `verify_start` on entry to VERIFY. `arr_cards_out` is frozen during SHOW and VERIFY.
- `verify_done` outside VERIFY is ignored. `move_next`/`select` in IDLE, SHOW and VERIFY are ignored.

## Timing
- Reset values:
  - state IDLE, `cursor` 0;
  - all `arr_cards_out` entries 5'b00011;
  - `verify_start`, `turn_end`, `turn_timeout`, `busy` all 0;
  - timers 0.
- All outputs are registered. Pulses are exactly one cycle.
- From the valid second select to the `verify_start` pulse: SHOW_CYCLES+1 cycles.
- From `verify_done` to the `turn_end` pulse: 1 cycle.
- From `turn_start` to `busy`=1: 1 cycle.
- `rst` mid-turn: everything returns to reset values on the next edge. Any opened card is discarded and no pulse is emitted.

## Structure
- Shared package `memoria_pkg`:
  - `N_CARDS` = 16;
  - card-state constants `CARD_DOWN`=2'b00, `CARD_OPEN`=2'b01, `CARD_MATCHED`=2'b10, `CARD_INIT`=2'b11;
  - a `card_t` 5-bit typedef;
  - the `sel_state_t` enum.
- Sub-module `contador_turno`: a loadable up-counter with clear and a terminal-count flag, instantiated twice (timeout and SHOW) with the width derived from the parameter.

## Test plan
- Reset, then `turn_start` with all cards 00 and symbol = index/2. Select at 0; move; select at 1 → cards 0/1 read 01; `verify_start` pulses SHOW_CYCLES+1 cycles after the second select. `verify_done` → `turn_end` on the next cycle, `busy`=0.
- Select on a 10 card, then select again on an already-open card → `arr_cards_out` unchanged and state stays SEL2.
- 15 `move_next` then one more → cursor 15 then 0. `select` together with `move_next` at cursor 3 → card 3 opens and cursor becomes 4.
- Run with TIMEOUT_CYCLES=20: open one card, then idle → at cycle 19 card returns to 00 and `turn_end` and `turn_timeout` pulse together. A select on the expiry cycle opens the card with no timeout.
- `turn_start` with all cards 10 → `turn_end` next cycle, `verify_start` never asserted.
- `rst` asserted during SHOW → all cards 00011, cursor 0, no `verify_start`. A `turn_start` and `verify_done` pulse asserted during SHOW are both ignored.
